// File: rtl/face_det_pkg.sv
// Shared constants for the face-detection datapath: default widths, image size and
// the integral-image builder state encoding.
package face_det_pkg;
    localparam int WIDTH_PIX       = 8;
    localparam int WIDTH_INTE      = 20;
    localparam int WIDTH_INTE_ADDR = 16;
    localparam int WIDTH_POSI      = 6;
    localparam int IMG_W           = 64;
    localparam int IMG_H           = 64;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SOF = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    // Counter width for a coordinate ranging over 0..n-1 (at least one bit).
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/int_line_buffer.sv
// One row of integral values (previous row's II), written synchronously and read
// combinationally by column index.
module int_line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 20,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/integral_image_builder.sv
// Streams raster-order pixels into integral-image BRAM writes, one registered write per
// accepted pixel, under the write_next_frame / new_image_ready handshake.
module integral_image_builder
    import face_det_pkg::*;
#(
    parameter int IMG_W           = face_det_pkg::IMG_W,
    parameter int IMG_H           = face_det_pkg::IMG_H,
    parameter int WIDTH_PIX       = face_det_pkg::WIDTH_PIX,
    parameter int WIDTH_INTE      = face_det_pkg::WIDTH_INTE,
    parameter int WIDTH_INTE_ADDR = face_det_pkg::WIDTH_INTE_ADDR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_next_frame,
    output logic                       new_image_ready,
    input  logic                       pix_sof,
    input  logic                       pix_valid,
    input  logic [WIDTH_PIX-1:0]       pix_data,
    output logic                       we_int,
    output logic [WIDTH_INTE_ADDR-1:0] waddr_int,
    output logic [WIDTH_INTE-1:0]      wdata_int,
    output logic                       busy
);
    localparam int XW = pos_width(IMG_W);
    localparam int YW = pos_width(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [1:0]            state_q, state_d;
    logic [XW-1:0]         x_q, x_d, cur_x;
    logic [YW-1:0]         y_q, y_d, cur_y;
    logic [WIDTH_INTE-1:0] row_sum_q, row_sum_d, row_sum_new, above, ii, lb_rdata;
    logic                  nir_q, nir_d;
    logic                  accept, restart, last_pix;

    // A pix_sof pixel always lands at (0,0); row 0 ignores whatever the line buffer holds.
    always_comb begin
        restart     = pix_valid & pix_sof & ((state_q == WAIT_SOF) | (state_q == CAPTURE));
        accept      = restart | (pix_valid & (state_q == CAPTURE));
        cur_x       = restart ? '0 : x_q;
        cur_y       = restart ? '0 : y_q;
        row_sum_new = ((cur_x == '0) ? '0 : row_sum_q) + WIDTH_INTE'(pix_data);
        above       = (cur_y == '0) ? '0 : lb_rdata;
        ii          = row_sum_new + above;
        last_pix    = accept & (cur_x == X_LAST) & (cur_y == Y_LAST);
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        row_sum_d = row_sum_q;
        nir_d     = nir_q;
        case (state_q)
            IDLE: begin
                if (write_next_frame) begin
                    state_d = WAIT_SOF;
                    nir_d   = 1'b0;
                end
            end
            WAIT_SOF, CAPTURE: begin
                if (accept) begin
                    state_d = last_pix ? DONE : CAPTURE;
                    if (last_pix) begin
                        x_d       = '0;
                        y_d       = '0;
                        row_sum_d = '0;
                    end else if (cur_x == X_LAST) begin
                        x_d       = '0;
                        y_d       = cur_y + YW'(1);
                        row_sum_d = '0;
                    end else begin
                        x_d       = cur_x + XW'(1);
                        y_d       = cur_y;
                        row_sum_d = row_sum_new;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                nir_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            row_sum_q <= '0;
            nir_q     <= 1'b0;
            we_int    <= 1'b0;
            waddr_int <= '0;
            wdata_int <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_sum_q <= row_sum_d;
            nir_q     <= nir_d;
            we_int    <= accept;
            if (accept) begin
                waddr_int <= WIDTH_INTE_ADDR'(cur_y) * WIDTH_INTE_ADDR'(IMG_W)
                             + WIDTH_INTE_ADDR'(cur_x);
                wdata_int <= ii;
            end
        end
    end

    int_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (WIDTH_INTE),
        .AW    (XW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (accept),
        .waddr (cur_x),
        .wdata (ii),
        .raddr (cur_x),
        .rdata (lb_rdata)
    );

    assign new_image_ready = nir_q;
    assign busy            = (state_q == WAIT_SOF) || (state_q == CAPTURE);
endmodule

// File: tb/tb_integral_image_builder.sv
// Scoreboard bench: a 4x3 instance for handshake/corner cases and a default 64x64
// instance for the full-size all-255 frame.
module tb_integral_image_builder;
    localparam int SW = 4;
    localparam int SH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_wnf = 0, s_nir, s_sof = 0, s_valid = 0, s_we, s_busy;
    logic [7:0]  s_pix = '0;
    logic [15:0] s_waddr;
    logic [19:0] s_wdata;
    logic        b_wnf = 0, b_nir, b_sof = 0, b_valid = 0, b_we, b_busy;
    logic [7:0]  b_pix = '0;
    logic [15:0] b_waddr;
    logic [19:0] b_wdata;

    integral_image_builder #(
        .IMG_W (SW),
        .IMG_H (SH)
    ) u_small (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_next_frame (s_wnf),
        .new_image_ready  (s_nir),
        .pix_sof          (s_sof),
        .pix_valid        (s_valid),
        .pix_data         (s_pix),
        .we_int           (s_we),
        .waddr_int        (s_waddr),
        .wdata_int        (s_wdata),
        .busy             (s_busy)
    );

    integral_image_builder u_big (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_next_frame (b_wnf),
        .new_image_ready  (b_nir),
        .pix_sof          (b_sof),
        .pix_valid        (b_valid),
        .pix_data         (b_pix),
        .we_int           (b_we),
        .waddr_int        (b_waddr),
        .wdata_int        (b_wdata),
        .busy             (b_busy)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [19:0] data;
    } wr_t;

    wr_t s_q[$];
    wr_t b_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  s_writes = 0;
    int  b_writes = 0;
    int  frame_ii[12] = '{1, 3, 6, 10, 6, 14, 24, 36, 15, 33, 54, 78};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic s_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 0; s_sof = 0; s_wnf = 0;
        end
    endtask

    task automatic s_request();
        @(negedge clk);
        s_valid = 0; s_sof = 0; s_wnf = 1;
    endtask

    task automatic s_pixel(input int v, input bit sof, input bit exp_wr, input int a,
                           input int d);
        @(negedge clk);
        s_valid = 1; s_sof = sof; s_pix = 8'(v); s_wnf = 0;
        if (exp_wr) s_q.push_back('{addr: 16'(a), data: 20'(d)});
    endtask

    // Pixels 1..12 with pix_sof on the first; optional random idle gaps and one
    // write_next_frame pulse while busy.
    task automatic s_frame(input bit gaps);
        for (int i = 0; i < SW * SH; i++) begin
            if (gaps) begin
                if (i == 5) s_request();
                s_idle($urandom_range(0, 2));
            end
            s_pixel(i + 1, i == 0, 1, i, frame_ii[i]);
        end
    endtask

    task automatic b_cycle(input bit valid, input bit sof, input bit wnf);
        @(negedge clk);
        b_valid = valid; b_sof = sof; b_wnf = wnf; b_pix = 8'd255;
    endtask

    task automatic stimulus();
        int w0;
        repeat (2) @(negedge clk);
        check("reset_nir", s_nir, 0);
        check("reset_we", s_we, 0);
        check("reset_waddr", s_waddr, 0);
        check("reset_wdata", s_wdata, 0);
        check("reset_busy", s_busy, 0);
        check("reset_big_we", b_we, 0);
        rst_n = 1;

        // Pixels in IDLE, even with pix_sof, produce nothing.
        w0 = s_writes;
        for (int i = 0; i < 3; i++) s_pixel(i + 5, 1, 0, 0, 0);
        s_idle(2);
        check("idle_busy", s_busy, 0);
        check("idle_no_write", s_writes, w0);

        s_request();
        s_idle(1);
        check("busy_after_request", s_busy, 1);
        for (int i = 0; i < 3; i++) s_pixel(50 + i, 0, 0, 0, 0);
        s_idle(2);
        check("wait_sof_no_write", s_writes, w0);
        check("wait_sof_busy", s_busy, 1);

        // Scenario 1: plain 4x3 frame.
        s_frame(0);
        s_idle(1);
        check("final_we", s_we, 1);
        check("final_waddr", s_waddr, 11);
        check("nir_low_on_final", s_nir, 0);
        s_idle(1);
        check("nir_rise", s_nir, 1);
        s_idle(2);
        check("nir_hold", s_nir, 1);
        check("drained_1", s_q.size(), 0);
        check("writes_1", s_writes - w0, 12);

        // Gappy frame, request while busy, request on the final-write cycle.
        s_request();
        s_idle(1);
        check("nir_clear", s_nir, 0);
        w0 = s_writes;
        s_frame(1);
        @(negedge clk);
        s_valid = 0; s_sof = 0; s_wnf = 1;
        check("gap_final_waddr", s_waddr, 11);
        check("gap_nir_low", s_nir, 0);
        s_idle(1);
        check("gap_nir_rise", s_nir, 1);
        s_idle(1);
        check("late_req_ignored_nir", s_nir, 1);
        check("late_req_ignored_busy", s_busy, 0);
        check("gap_writes", s_writes - w0, 12);
        check("drained_2", s_q.size(), 0);

        // Restart: pix_sof on the 7th pixel.
        s_request();
        s_idle(1);
        for (int i = 0; i < 6; i++) s_pixel(i + 1, i == 0, 1, i, frame_ii[i]);
        check("nir_low_partial", s_nir, 0);
        s_frame(0);
        s_idle(1);
        check("restart_final_waddr", s_waddr, 11);
        check("restart_nir_low", s_nir, 0);
        s_idle(1);
        check("restart_nir_rise", s_nir, 1);
        check("drained_3", s_q.size(), 0);

        // Reset in the middle of a capture.
        s_request();
        s_idle(1);
        for (int i = 0; i < 5; i++) s_pixel(i + 1, i == 0, 1, i, frame_ii[i]);
        s_idle(2);
        rst_n = 0;
        #1;
        check("midreset_we", s_we, 0);
        check("midreset_waddr", s_waddr, 0);
        check("midreset_wdata", s_wdata, 0);
        check("midreset_busy", s_busy, 0);
        check("midreset_nir", s_nir, 0);
        s_idle(2);
        rst_n = 1;
        s_request();
        s_idle(1);
        s_frame(0);
        s_idle(2);
        check("post_reset_nir", s_nir, 1);
        check("drained_4", s_q.size(), 0);

        // Full-size 64x64 frame of 255s, continuous valid.
        w0 = b_writes;
        b_cycle(0, 0, 1);
        for (int i = 0; i < 4096; i++) begin
            b_cycle(1, i == 0, 0);
            b_q.push_back('{addr: 16'(i), data: 20'(255 * (i % 64 + 1) * (i / 64 + 1))});
        end
        b_cycle(0, 0, 0);
        check("big_final_waddr", b_waddr, 4095);
        check("big_final_wdata", b_wdata, 1044480);
        check("big_nir_low", b_nir, 0);
        b_cycle(0, 0, 0);
        check("big_nir_rise", b_nir, 1);
        check("big_writes", b_writes - w0, 4096);
        check("big_drained", b_q.size(), 0);
    endtask

    initial begin
        fork
            stimulus();
            forever begin
                wr_t e;
                @(negedge clk);
                if (s_we === 1'b1) begin
                    s_writes++;
                    if (s_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL s_unexpected_write: got addr %0d data %0d, required none",
                                 s_waddr, s_wdata);
                    end else begin
                        e = s_q.pop_front();
                        check("s_waddr", s_waddr, e.addr);
                        check("s_wdata", s_wdata, e.data);
                    end
                end
                if (b_we === 1'b1) begin
                    b_writes++;
                    if (b_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL b_unexpected_write: got addr %0d data %0d, required none",
                                 b_waddr, b_wdata);
                    end else begin
                        e = b_q.pop_front();
                        check("b_waddr", b_waddr, e.addr);
                        check("b_wdata", b_wdata, e.data);
                    end
                end
            end
            begin
                #500000;
                vectors++;
                miscompares++;
                $display("FAIL watchdog: got timeout, required completion");
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
